// File: rtl/pulse_hp_pkg.sv
// Shared types for the high-period pulse path (transmit generator and receive counter).
//   CNT_W      : width of the WIDTH/GAP fields and of the down-counter
//   hp_state_t : FSM states IDLE / HIGH / GAP
//   hp_req_t   : pulse request payload {width, gap}
//   eff_gap    : effective LOW length, max(gap, min_gap), never below one cycle
package pulse_hp_pkg;

  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } hp_state_t;

  typedef struct packed {
    logic [CNT_W-1:0] width;
    logic [CNT_W-1:0] gap;
  } hp_req_t;

  // Zero-length gap is clamped to one cycle so the GAP load value never wraps.
  function automatic logic [CNT_W-1:0] eff_gap(input logic [CNT_W-1:0] gap,
                                               input logic [CNT_W-1:0] min_gap);
    logic [CNT_W-1:0] g;
    g = (gap > min_gap) ? gap : min_gap;
    if (g == '0) g = CNT_W'(1);
    return g;
  endfunction

endpackage

// File: rtl/hp_req_buf.sv
// One-entry valid/ready holding register (bypass-free: output is valid only when full).
//   sys_clk, a_reset        : clock, async active-low reset (entry discarded)
//   in_valid/in_ready/in_data    : write side, in_ready = ~full
//   out_valid/out_ready/out_data : read side, out_valid = full
module hp_req_buf
  import pulse_hp_pkg::*;
(
  input  logic    sys_clk,
  input  logic    a_reset,
  input  logic    in_valid,
  output logic    in_ready,
  input  hp_req_t in_data,
  output logic    out_valid,
  input  logic    out_ready,
  output hp_req_t out_data
);

  logic    full;
  hp_req_t data;

  assign in_ready  = ~full;
  assign out_valid = full;
  assign out_data  = data;

  // Push only when empty, so push and pop never coincide.
  always_ff @(posedge sys_clk or negedge a_reset) begin
    if (!a_reset) begin
      full <= 1'b0;
      data <= '0;
    end else if (in_valid && in_ready) begin
      full <= 1'b1;
      data <= in_data;
    end else if (out_ready && full) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/pulse_gen_hp.sv
// Pulse generator: drives PULSE high for WIDTH cycles, then low for max(GAP, MIN_GAP).
//   sys_clk, a_reset : clock, async active-low reset
//   req_valid/req_ready, req_width, req_gap : request handshake (one-entry buffer behind it)
//   pulse : generated pulse (registered)
//   busy  : FSM not idle or holding register full (registered)
//   done  : one-cycle strobe on the last LOW cycle of each request (registered)
// MIN_GAP is truncated to CNT_W bits and must not exceed 2^CNT_W-1.
module pulse_gen_hp
  import pulse_hp_pkg::*;
#(
  parameter int unsigned MIN_GAP = 1
) (
  input  logic             sys_clk,
  input  logic             a_reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CNT_W-1:0] req_width,
  input  logic [CNT_W-1:0] req_gap,
  output logic             pulse,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] MIN_GAP_W = CNT_W'(MIN_GAP);

  hp_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] gap_cur, gap_nxt;
  logic             pulse_nxt, done_nxt, busy_nxt;

  hp_req_t req_in, hold_data, next_req;
  logic    hold_valid, hold_pop, buf_in_valid;
  logic    take, bypass, load, hold_full_nxt;

  assign req_in = '{width: req_width, gap: req_gap};

  hp_req_buf u_buf (
    .sys_clk   (sys_clk),
    .a_reset   (a_reset),
    .in_valid  (buf_in_valid),
    .in_ready  (req_ready),
    .in_data   (req_in),
    .out_valid (hold_valid),
    .out_ready (hold_pop),
    .out_data  (hold_data)
  );

  // FSM may accept a new request when idle or on the final GAP cycle; HOLD has priority.
  always_comb begin
    take          = (state == IDLE) || ((state == GAP) && (cnt == '0));
    bypass        = take && !hold_valid && req_valid;
    hold_pop      = take && hold_valid;
    buf_in_valid  = req_valid && !bypass;
    load          = hold_pop || bypass;
    next_req      = hold_valid ? hold_data : req_in;
    hold_full_nxt = hold_valid ? !hold_pop : (buf_in_valid && req_ready);
  end

  // Next-state, counter and output logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gap_nxt   = gap_cur;
    pulse_nxt = pulse;

    case (state)
      IDLE: begin
        pulse_nxt = 1'b0;
      end
      HIGH: begin
        if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = gap_cur - CNT_W'(1);
          pulse_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        pulse_nxt = 1'b0;
      end
    endcase

    // A load overrides the IDLE/GAP-final transition; zero width skips HIGH.
    if (load) begin
      gap_nxt = eff_gap(next_req.gap, MIN_GAP_W);
      if (next_req.width == '0) begin
        state_nxt = GAP;
        cnt_nxt   = gap_nxt - CNT_W'(1);
        pulse_nxt = 1'b0;
      end else begin
        state_nxt = HIGH;
        cnt_nxt   = next_req.width - CNT_W'(1);
        pulse_nxt = 1'b1;
      end
    end

    done_nxt = (state_nxt == GAP) && (cnt_nxt == '0);
    busy_nxt = (state_nxt != IDLE) || hold_full_nxt;
  end

  always_ff @(posedge sys_clk or negedge a_reset) begin
    if (!a_reset) begin
      state   <= IDLE;
      cnt     <= '0;
      gap_cur <= '0;
      pulse   <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      gap_cur <= gap_nxt;
      pulse   <= pulse_nxt;
      done    <= done_nxt;
      busy    <= busy_nxt;
    end
  end

endmodule
